// File: rtl/seg7_scan_ctrl_if.sv
// Load handshake between a producer and the seven-segment scan controller.
interface seg7_scan_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  load_valid;
  logic                  load_ready;
  logic [4*DIGITS-1:0]   load_data;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scanner with tear-free double-buffered load.
// Define SEG7_SCAN_LZB_EN to enable leading-zero blanking.
module seg7_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DWELL  = 1000,
  parameter int BLANK  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  seg7_scan_ctrl_if.slave   load,
  output logic [6:0]        segments,
  output logic [DIGITS-1:0] digit_en,
  output logic              frame_pulse
);
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int DW   = 4 * DIGITS;

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t          state, nxt_state;
  logic [IW-1:0]   idx, nxt_idx;
  logic [CW-1:0]   cnt, nxt_cnt;
  logic [DW-1:0]   disp, nxt_disp, shadow;
  logic            pending, nxt_pending;
  logic            running, boundary, dark;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h58;  4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

  assign load.load_ready = ~pending;

  // Next-state is computed here so the registered outputs can be loaded from
  // it and therefore match the FSM state in the same cycle.
  always_comb begin
    nxt_state   = state;
    nxt_idx     = idx;
    nxt_cnt     = cnt;
    boundary    = 1'b0;
    if (!enable) begin
      nxt_state = ST_BLANK;
      nxt_idx   = '0;
      nxt_cnt   = '0;
    end else if (!running) begin
      nxt_state = ST_BLANK;
      nxt_idx   = '0;
      nxt_cnt   = '0;
      boundary  = 1'b1;
    end else if (state == ST_BLANK) begin
      if (cnt == CW'(BLANK - 1)) begin
        nxt_state = ST_SHOW;
        nxt_cnt   = '0;
      end else begin
        nxt_cnt = cnt + 1'b1;
      end
    end else begin
      if (cnt == CW'(DWELL - 1)) begin
        nxt_state = ST_BLANK;
        nxt_cnt   = '0;
        if (idx == IW'(DIGITS - 1)) begin
          nxt_idx  = '0;
          boundary = 1'b1;
        end else begin
          nxt_idx = idx + 1'b1;
        end
      end else begin
        nxt_cnt = cnt + 1'b1;
      end
    end

    nxt_disp    = disp;
    nxt_pending = pending;
    if (pending && (boundary || !enable)) begin
      nxt_disp    = shadow;
      nxt_pending = 1'b0;
    end else if (load.load_valid && !pending) begin
      nxt_pending = 1'b1;
    end
  end

`ifdef SEG7_SCAN_LZB_EN
  assign dark = (nxt_idx != '0) && ((nxt_disp >> {nxt_idx, 2'b00}) == '0);
`else
  assign dark = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BLANK;
      idx         <= '0;
      cnt         <= '0;
      disp        <= '0;
      shadow      <= '0;
      pending     <= 1'b0;
      running     <= 1'b0;
      segments    <= '0;
      digit_en    <= '0;
      frame_pulse <= 1'b0;
    end else begin
      state       <= nxt_state;
      idx         <= nxt_idx;
      cnt         <= nxt_cnt;
      disp        <= nxt_disp;
      pending     <= nxt_pending;
      running     <= enable;
      frame_pulse <= boundary;
      if (load.load_valid && !pending)
        shadow <= load.load_data;
      if (nxt_state == ST_SHOW && !dark) begin
        segments <= glyph(nxt_disp[4*nxt_idx +: 4]);
        digit_en <= DIGITS'(1) << nxt_idx;
      end else begin
        segments <= '0;
        digit_en <= '0;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl with DIGITS=4, DWELL=4, BLANK=2.
module tb_seg7_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [6:0] segments;
  logic [3:0] digit_en;
  logic       frame_pulse;

  seg7_scan_ctrl_if #(.DIGITS(4)) lif();

  seg7_scan_ctrl #(.DIGITS(4), .DWELL(4), .BLANK(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .load        (lif),
    .segments    (segments),
    .digit_en    (digit_en),
    .frame_pulse (frame_pulse)
  );

  always #5 clk = ~clk;

`ifdef SEG7_SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    logic [6:0] seg;
    logic [3:0] den;
    logic       fp;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   pass_cnt = 0;
  int   total    = 0;
  int   cnt_all  = 0;
  int   base     = 0;

  always @(posedge clk) cnt_all <= cnt_all + 1;

  function automatic int cyc();
    return cnt_all - base - 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc(), act, exp);
    else
      pass_cnt++;
  endtask

  // Hand-built schedule: per digit 2 blank cycles then 4 lit cycles.
  task automatic push_frame(input logic [15:0] v, input int n);
    exp_t e;
    int   k = 0;
    for (int d = 0; d < 4; d++) begin
      for (int j = 0; j < 6; j++) begin
        if (k < n) begin
          if (j < 2) begin
            e.seg = '0; e.den = '0; e.fp = (d == 0 && j == 0);
          end else if (LZB && d > 0 && (v >> (4*d)) == 16'h0) begin
            e.seg = '0; e.den = '0; e.fp = 1'b0;
          end else begin
            e.seg = GLYPH[v[4*d +: 4]]; e.den = 4'(1 << d); e.fp = 1'b0;
          end
          q.push_back(e);
        end
        k++;
      end
    end
  endtask

  task automatic push_zero(input int n);
    exp_t e;
    e.seg = '0; e.den = '0; e.fp = 1'b0;
    for (int i = 0; i < n; i++) q.push_back(e);
  endtask

  task automatic goto(input int c);
    while (cyc() < c) @(negedge clk);
  endtask

  task automatic offer(input logic [15:0] d);
    int n = 0;
    lif.load_valid = 1'b1;
    lif.load_data  = d;
    while (!lif.load_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("offer_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1 lif.load_valid = 1'b0;
  endtask

  // Monitor: one expected entry per cycle while the scoreboard holds entries.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && q.size() > 0) begin
        me = q.pop_front();
        check("segments", 32'(segments), 32'(me.seg));
        check("digit_en", 32'(digit_en), 32'(me.den));
        check("frame_pulse", 32'(frame_pulse), 32'(me.fp));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n          = 1'b0;
    enable         = 1'b0;
    lif.load_valid = 1'b0;
    lif.load_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_segments", 32'(segments), 32'd0);
    check("rst_digit_en", 32'(digit_en), 32'd0);
    check("rst_frame_pulse", 32'(frame_pulse), 32'd0);
    check("rst_load_ready", 32'(lif.load_ready), 32'd1);

    rst_n  = 1'b1;
    enable = 1'b1;
    base   = cnt_all;
    #1;
    push_frame(16'h0000, 24);   // cycles   0..23
    push_frame(16'h12AF, 24);   // cycles  24..47
    push_frame(16'h12AF, 24);   // cycles  48..71
    push_frame(16'h0000, 24);   // cycles  72..95
    push_frame(16'h8888, 24);   // cycles  96..119
    push_frame(16'h8888, 16);   // cycles 120..135, disabled mid digit 2
    push_zero(4);               // cycles 136..139
    push_frame(16'h5555, 24);   // cycles 140..163
    push_frame(16'h0050, 10);   // cycles 164..173, reset during digit 1

    goto(3);
    offer(16'h12AF);
    @(negedge clk);
    check("ready_low_pending", 32'(lif.load_ready), 32'd0);

    goto(51);
    offer(16'h0000);
    @(negedge clk);
    lif.load_valid = 1'b1;
    lif.load_data  = 16'h3333;
    check("ready_low_hold1", 32'(lif.load_ready), 32'd0);
    @(negedge clk);
    check("ready_low_hold2", 32'(lif.load_ready), 32'd0);
    lif.load_data = 16'h8888;
    n = 0;
    while (!lif.load_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_at_boundary", 32'(cyc()), 32'd72);
    @(posedge clk);
    #1 lif.load_valid = 1'b0;

    goto(135);
    enable = 1'b0;
    goto(136);
    offer(16'h5555);
    goto(139);
    enable = 1'b1;

    goto(145);
    offer(16'h0050);
    goto(168);
    offer(16'h1234);

    goto(173);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_segments", 32'(segments), 32'd0);
    check("async_rst_digit_en", 32'(digit_en), 32'd0);
    check("async_rst_frame_pulse", 32'(frame_pulse), 32'd0);
    check("async_rst_load_ready", 32'(lif.load_ready), 32'd1);
    goto(176);
    rst_n = 1'b1;
    #1;
    check("post_rst_load_ready", 32'(lif.load_ready), 32'd1);
    push_frame(16'h0000, 24);   // cycles 177..200
    push_frame(16'h0000, 24);   // cycles 201..224

    goto(226);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
